// File: rtl/hazard_if.sv
// D-stage hazard bundle: decoder-side operand/writer info in, stall and forward selects out.
interface hazard_if #(
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 3,
  parameter int SEL_W  = 2
);
  logic              flush;
  logic [ADDR_W-1:0] d_rs;
  logic [ADDR_W-1:0] d_rt;
  logic [TNEW_W-1:0] d_tuse_rs;
  logic [TNEW_W-1:0] d_tuse_rt;
  logic              d_regwrite;
  logic [ADDR_W-1:0] d_regaddr;
  logic [TNEW_W-1:0] d_tnew;
  logic              stall;
  logic [SEL_W-1:0]  fwd_rs_sel;
  logic [SEL_W-1:0]  fwd_rt_sel;

  modport master (
    output flush, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regwrite, d_regaddr, d_tnew,
    input  stall, fwd_rs_sel, fwd_rt_sel
  );

  modport slave (
    input  flush, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_regwrite, d_regaddr, d_tnew,
    output stall, fwd_rs_sel, fwd_rt_sel
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based stall/forward controller for the D stage.
// Optional HAZARD_PERF_EN adds a 32-bit stall cycle counter (stall_cnt).
module hazard_scoreboard #(
  parameter int STAGES = 3,
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 3,
  parameter int SEL_W  = 2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef HAZARD_PERF_EN
  output logic [31:0] stall_cnt,
`endif
  hazard_if.slave     hz
);

  logic              v    [STAGES];
  logic [ADDR_W-1:0] addr [STAGES];
  logic [TNEW_W-1:0] tnew [STAGES];

  logic              hit_rs, hit_rt;
  logic [SEL_W-1:0]  j_rs, j_rt;
  logic [TNEW_W-1:0] tn_rs, tn_rt;
  logic              haz_rs, haz_rt;

  // Scan oldest to youngest so the youngest matching writer wins.
  always_comb begin
    hit_rs = 1'b0;
    j_rs   = '0;
    tn_rs  = '0;
    hit_rt = 1'b0;
    j_rt   = '0;
    tn_rt  = '0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      if (v[j] && addr[j] == hz.d_rs && hz.d_rs != '0) begin
        hit_rs = 1'b1;
        j_rs   = SEL_W'(j);
        tn_rs  = tnew[j];
      end
      if (v[j] && addr[j] == hz.d_rt && hz.d_rt != '0) begin
        hit_rt = 1'b1;
        j_rt   = SEL_W'(j);
        tn_rt  = tnew[j];
      end
    end
  end

  // E has no forward path back to D, so a Tuse=0 match in entry 0 must stall.
  assign haz_rs = hit_rs && ((tn_rs > hz.d_tuse_rs) ||
                             (j_rs == '0 && hz.d_tuse_rs == '0));
  assign haz_rt = hit_rt && ((tn_rt > hz.d_tuse_rt) ||
                             (j_rt == '0 && hz.d_tuse_rt == '0));

  assign hz.stall      = haz_rs | haz_rt;
  assign hz.fwd_rs_sel = (hit_rs && j_rs != '0 && tn_rs == '0) ? j_rs : '0;
  assign hz.fwd_rt_sel = (hit_rt && j_rt != '0 && tn_rt == '0) ? j_rt : '0;

  always_ff @(posedge clk) begin
    if (reset || hz.flush) begin
      for (int j = 0; j < STAGES; j++) begin
        v[j]    <= 1'b0;
        addr[j] <= '0;
        tnew[j] <= '0;
      end
    end else begin
      if (hz.stall) begin
        v[0]    <= 1'b0;
        addr[0] <= '0;
        tnew[0] <= '0;
      end else begin
        v[0]    <= hz.d_regwrite && hz.d_regaddr != '0;
        addr[0] <= hz.d_regaddr;
        tnew[0] <= hz.d_tnew;
      end
      for (int j = 1; j < STAGES; j++) begin
        v[j]    <= v[j-1];
        addr[j] <= addr[j-1];
        tnew[j] <= (tnew[j-1] == '0) ? '0 : tnew[j-1] - 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  // Flush does not clear the counter; it tracks stalls across redirects.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (hz.stall)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (define HAZARD_PERF_EN to cover stall_cnt).
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
`endif

  hazard_if #(.ADDR_W(5), .TNEW_W(3), .SEL_W(2)) hz ();

  hazard_scoreboard #(.STAGES(3), .ADDR_W(5), .TNEW_W(3), .SEL_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef HAZARD_PERF_EN
    .stall_cnt (stall_cnt),
`endif
    .hz        (hz)
  );

  always #5 clk = ~clk;

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hz.flush      = 1'b0;
    hz.d_rs       = '0;
    hz.d_rt       = '0;
    hz.d_tuse_rs  = '0;
    hz.d_tuse_rt  = '0;
    hz.d_regwrite = 1'b0;
    hz.d_regaddr  = '0;
    hz.d_tnew     = '0;
  endtask

  task automatic writer(input logic [4:0] a, input logic [2:0] t);
    idle();
    hz.d_regwrite = 1'b1;
    hz.d_regaddr  = a;
    hz.d_tnew     = t;
  endtask

  task automatic reader(input logic [4:0] rs, input logic [2:0] urs,
                        input logic [4:0] rt, input logic [2:0] urt);
    idle();
    hz.d_rs      = rs;
    hz.d_tuse_rs = urs;
    hz.d_rt      = rt;
    hz.d_tuse_rt = urt;
  endtask

  task automatic chk(input string tag, input logic s, input logic [1:0] rs, input logic [1:0] rt);
    @(negedge clk);
    checks++;
    assert (hz.stall === s) else begin
      errors++;
      $error("FAIL %s stall observed %0b expected %0b", tag, hz.stall, s);
    end
    checks++;
    assert (hz.fwd_rs_sel === rs) else begin
      errors++;
      $error("FAIL %s fwd_rs_sel observed %0d expected %0d", tag, hz.fwd_rs_sel, rs);
    end
    checks++;
    assert (hz.fwd_rt_sel === rt) else begin
      errors++;
      $error("FAIL %s fwd_rt_sel observed %0d expected %0d", tag, hz.fwd_rt_sel, rt);
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    @(negedge clk);
    checks++;
    assert (stall_cnt === exp) else begin
      errors++;
      $error("FAIL %s stall_cnt observed %0d expected %0d", tag, stall_cnt, exp);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle();
    go();
    go();
    reset = 1'b0;
    chk("reset", 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_PERF_EN
    chk_cnt("reset_cnt", 32'd0);
`endif
    go();

    // lw $8 (Tnew 2), reader of $8 with Tuse_rs 1
    writer(5'd8, 3'd2);
    chk("t1_lw", 1'b0, 2'd0, 2'd0);
    go();
    reader(5'd8, 3'd1, 5'd0, 3'd0);
    chk("t1_stall", 1'b1, 2'd0, 2'd0);
    go();
    chk("t1_nostall_m", 1'b0, 2'd0, 2'd0);
    go();
    chk("t1_fwd_w", 1'b0, 2'd2, 2'd0);
    go();
    idle();
    go();

    // addu $9 (Tnew 1), beq $9,$9 with Tuse 0
    writer(5'd9, 3'd1);
    chk("t2_addu", 1'b0, 2'd0, 2'd0);
    go();
    reader(5'd9, 3'd0, 5'd9, 3'd0);
    chk("t2_stall", 1'b1, 2'd0, 2'd0);
    go();
    chk("t2_fwd_m", 1'b0, 2'd1, 2'd1);
    go();
    idle();
    go();
    go();

    // older writer $10 (Tnew 3) then younger addu $10 (Tnew 1)
    writer(5'd10, 3'd3);
    go();
    writer(5'd10, 3'd1);
    chk("t3_addu", 1'b0, 2'd0, 2'd0);
    go();
    reader(5'd10, 3'd1, 5'd0, 3'd0);
    chk("t3_young_e", 1'b0, 2'd0, 2'd0);
    go();
    reader(5'd0, 3'd0, 5'd10, 3'd0);
    chk("t3_young_m", 1'b0, 2'd0, 2'd1);
    go();
    idle();
    go();
    go();

    // writer to $0, reader of $0
    writer(5'd0, 3'd2);
    chk("t4_w0", 1'b0, 2'd0, 2'd0);
    go();
    reader(5'd0, 3'd0, 5'd0, 3'd0);
    chk("t4_r0_e", 1'b0, 2'd0, 2'd0);
    go();
    chk("t4_r0_m", 1'b0, 2'd0, 2'd0);
    go();
    idle();
    go();

    // flush while stalled on lw $8
    writer(5'd8, 3'd2);
    go();
    reader(5'd8, 3'd0, 5'd0, 3'd0);
    hz.flush = 1'b1;
    chk("t5_flush_cyc", 1'b1, 2'd0, 2'd0);
    go();
    hz.flush = 1'b0;
    chk("t5_flushed", 1'b0, 2'd0, 2'd0);
    go();
    idle();
    go();

    // reset while stalled on lw $8
    writer(5'd8, 3'd2);
    go();
    reader(5'd8, 3'd0, 5'd0, 3'd0);
    chk("t5_stall_b", 1'b1, 2'd0, 2'd0);
    reset = 1'b1;
    go();
    reset = 1'b0;
    chk("t5_reset", 1'b0, 2'd0, 2'd0);
    go();
    idle();
    go();

`ifdef HAZARD_PERF_EN
    chk_cnt("perf_after_reset", 32'd0);
    for (int k = 0; k < 3; k++) begin
      writer(5'd9, 3'd1);
      go();
      reader(5'd9, 3'd0, 5'd0, 3'd0);
      go();
      idle();
      go();
      go();
    end
    chk_cnt("perf_three", 32'd3);
    hz.flush = 1'b1;
    go();
    hz.flush = 1'b0;
    chk_cnt("perf_flush", 32'd3);
    reset = 1'b1;
    go();
    reset = 1'b0;
    chk_cnt("perf_reset", 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
